pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives EN/CLR/bb of the IF/ID, ID/EX, EX/MEM and MEM/WB register banks and the PC enable.
- Resolves load-use hazards, taken-branch/jump flushes, multi-cycle MULT/DIV occupancy of EX, and SYSCALL halt/resume.
- Forwarding is handled elsewhere; this block only decides advance/freeze/bubble/squash per stage.

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline register banks and PC.
// Optional HAZARD_STATS_EN adds saturating hazard event counters.
module pipeline_hazard_ctrl #(
  parameter int MULT_LAT = 3,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_use_rs,
  input  logic       ID_use_rt,
  input  logic       EX_MemtoReg,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_WbRegNum,
  input  logic       EX_redirect,
  input  logic       EX_md_start,
  input  logic       EX_md_is_div,
  input  logic       WB_syscall_halt,
  input  logic       go,
  output logic       PC_EN,
  output logic       IFID_EN,
  output logic       IFID_CLR,
  output logic       IDEX_EN,
  output logic       IDEX_bb,
  output logic       IDEX_CLR,
  output logic       EXMEM_EN,
  output logic       EXMEM_bb,
  output logic       MEMWB_EN,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stat_lu,
  output logic [31:0] stat_md,
  output logic [31:0] stat_fl,
`endif
  output logic       halted
);

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    HALT
  } state_t;

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic in_run;
  logic in_halt;
  logic sys_halt;
  logic md_stall;
  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic act_md;
  logic act_fl;
  logic act_lu;

  assign in_run   = (state == RUN);
  assign in_halt  = (state == HALT);
  assign sys_halt = WB_syscall_halt & !in_halt;
  assign md_stall = (in_run & EX_md_start)
                  | ((state == MD_BUSY) & (cnt != '0));
  assign rs_hit   = ID_use_rs & (ID_rs == EX_WbRegNum);
  assign rt_hit   = ID_use_rt & (ID_rt == EX_WbRegNum);
  assign load_use = in_run & EX_MemtoReg & EX_RegWrite
                  & (EX_WbRegNum != 5'd0) & (rs_hit | rt_hit);

  // which hazard actually owns the bank controls this cycle
  assign act_md = rst_n & !in_halt & !sys_halt & md_stall;
  assign act_fl = rst_n & !in_halt & !sys_halt & !md_stall
                & EX_redirect;
  assign act_lu = rst_n & !in_halt & !sys_halt & !md_stall
                & !EX_redirect & load_use;

  // state and busy counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state and busy countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (WB_syscall_halt) begin
          state_nxt = HALT;
          cnt_nxt   = '0;
        end else if (EX_md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = EX_md_is_div ? DIV_INIT : MUL_INIT;
        end
      end
      MD_BUSY: begin
        if (WB_syscall_halt) begin
          state_nxt = HALT;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (go) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // bank controls by hazard priority; reset forces free-run values
  always_comb begin
    PC_EN    = 1'b1;
    IFID_EN  = 1'b1;
    IFID_CLR = 1'b0;
    IDEX_EN  = 1'b1;
    IDEX_bb  = 1'b0;
    IDEX_CLR = 1'b0;
    EXMEM_EN = 1'b1;
    EXMEM_bb = 1'b0;
    MEMWB_EN = 1'b1;
    halted   = 1'b0;
    if (!rst_n) begin
      halted = 1'b0;
    end else if (in_halt || sys_halt) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_EN  = 1'b0;
      EXMEM_EN = 1'b0;
      MEMWB_EN = 1'b0;
      halted   = in_halt;
    end else if (md_stall) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_EN  = 1'b0;
      EXMEM_bb = 1'b1;
    end else if (EX_redirect) begin
      IFID_CLR = 1'b1;
      IDEX_CLR = 1'b1;
    end else if (load_use) begin
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
      IDEX_bb = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // saturating counters of cycles each hazard controlled the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu <= '0;
      stat_md <= '0;
      stat_fl <= '0;
    end else begin
      if (act_lu && stat_lu != 32'hFFFF_FFFF) stat_lu <= stat_lu + 1;
      if (act_md && stat_md != 32'hFFFF_FFFF) stat_md <= stat_md + 1;
      if (act_fl && stat_fl != 32'hFFFF_FFFF) stat_fl <= stat_fl + 1;
    end
  end
`else
  logic unused_act;
  assign unused_act = act_md ^ act_fl ^ act_lu;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Expected bank-control vectors are queued per driven cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_WbRegNum;
  logic       ID_use_rs, ID_use_rt;
  logic       EX_MemtoReg, EX_RegWrite, EX_redirect;
  logic       EX_md_start, EX_md_is_div;
  logic       WB_syscall_halt, go;
  logic       PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_bb;
  logic       IDEX_CLR, EXMEM_EN, EXMEM_bb, MEMWB_EN, halted;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_lu, stat_md, stat_fl;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [9:0] exp;
    string      tag;
  } sb_t;
  sb_t sbq[$];

  // {PC,IFID_EN,IFID_CLR,IDEX_EN,IDEX_bb,IDEX_CLR,EXMEM_EN,EXMEM_bb,MEMWB,halted}
  localparam logic [9:0] V_RUN = 10'b1101001010;
  localparam logic [9:0] V_FRZ = 10'b0000000000;
  localparam logic [9:0] V_HLT = 10'b0000000001;
  localparam logic [9:0] V_MD  = 10'b0000001110;
  localparam logic [9:0] V_FL  = 10'b1111011010;
  localparam logic [9:0] V_LU  = 10'b0001101010;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_WbRegNum(EX_WbRegNum), .EX_redirect(EX_redirect),
    .EX_md_start(EX_md_start), .EX_md_is_div(EX_md_is_div),
    .WB_syscall_halt(WB_syscall_halt), .go(go),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_CLR(IFID_CLR),
    .IDEX_EN(IDEX_EN), .IDEX_bb(IDEX_bb), .IDEX_CLR(IDEX_CLR),
    .EXMEM_EN(EXMEM_EN), .EXMEM_bb(EXMEM_bb),
    .MEMWB_EN(MEMWB_EN),
`ifdef HAZARD_STATS_EN
    .stat_lu(stat_lu), .stat_md(stat_md), .stat_fl(stat_fl),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_bb,
            IDEX_CLR, EXMEM_EN, EXMEM_bb, MEMWB_EN, halted};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // queue expectation, compare mid-cycle, then advance one edge
  task automatic step(input logic [9:0] exp, input string tag);
    sb_t e;
    sbq.push_back('{exp: exp, tag: tag});
    @(negedge clk);
    if (sbq.size() == 0) begin
      check({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check(e.tag, {22'd0, obs()}, {22'd0, e.exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 0; ID_use_rt = 0;
    EX_MemtoReg = 0; EX_RegWrite = 0; EX_WbRegNum = 5'd0;
    EX_redirect = 0; EX_md_start = 0; EX_md_is_div = 0;
    WB_syscall_halt = 0; go = 0;
  endtask

  task automatic lw_hit(input logic [4:0] rd);
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WbRegNum = rd;
    ID_rs = 5'd8; ID_use_rs = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step(V_RUN, "reset");
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    do_reset();
    step(V_RUN, "idle");

    // load-use on rs, then pipeline free
    lw_hit(5'd8);
    step(V_LU, "lu_rs");
    idle();
    step(V_RUN, "lu_after");
    // load-use on rt
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WbRegNum = 5'd12;
    ID_rt = 5'd12; ID_use_rt = 1;
    step(V_LU, "lu_rt");
    // rt match but not read
    ID_use_rt = 0;
    step(V_RUN, "lu_rt_unused");
    idle();
    // $0 destination never stalls
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_WbRegNum = 5'd0;
    ID_rs = 5'd0; ID_use_rs = 1;
    step(V_RUN, "lu_r0");
    idle();
    // redirect wins over load-use
    lw_hit(5'd8);
    EX_redirect = 1;
    step(V_FL, "flush_lu");
    idle();
    step(V_RUN, "flush_after");

    // DIV: 8 stall cycles, advance on 9th
    EX_md_start = 1; EX_md_is_div = 1;
    for (int i = 0; i < 8; i++) step(V_MD, $sformatf("div_%0d", i));
    step(V_RUN, "div_adv");
    idle();
    step(V_RUN, "div_done");

    // MULT: 3 stall cycles, redirect ignored while busy
    EX_md_start = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) EX_redirect = 1;
      step(V_MD, $sformatf("mul_%0d", i));
      EX_redirect = 0;
    end
    step(V_RUN, "mul_adv");
    idle();

    // SYSCALL halt and resume
    WB_syscall_halt = 1;
    step(V_FRZ, "sys_freeze");
    WB_syscall_halt = 0;
    for (int i = 0; i < 20; i++) step(V_HLT, $sformatf("halt_%0d", i));
    go = 1;
    step(V_HLT, "halt_go");
    go = 0;
    step(V_RUN, "resumed");
    go = 1;
    step(V_RUN, "go_in_run");
    go = 0;

    // SYSCALL during MD_BUSY drops the busy count
    EX_md_start = 1; EX_md_is_div = 1;
    step(V_MD, "md_sys_0");
    step(V_MD, "md_sys_1");
    WB_syscall_halt = 1;
    step(V_FRZ, "md_sys_frz");
    idle();
    step(V_HLT, "md_sys_halt");
    go = 1;
    step(V_HLT, "md_sys_go");
    go = 0;
    step(V_RUN, "md_sys_clear");

    // reset in cycle 4 of DIV, md_start still high
    EX_md_start = 1; EX_md_is_div = 1;
    for (int i = 0; i < 3; i++) step(V_MD, $sformatf("rdiv_%0d", i));
    rst_n = 0;
    #1;
    check("rst_async", {22'd0, obs()}, {22'd0, V_RUN});
    step(V_RUN, "rst_hold");
    EX_md_start = 0;
    rst_n = 1;
    step(V_RUN, "rst_rel_0");
    step(V_RUN, "rst_rel_1");

`ifdef HAZARD_STATS_EN
    do_reset();
    check("st_lu_rst", stat_lu, 32'd0);
    lw_hit(5'd8);
    step(V_LU, "st_lu0");
    idle();
    step(V_RUN, "st_gap");
    lw_hit(5'd8);
    step(V_LU, "st_lu1");
    idle();
    EX_md_start = 1;
    for (int i = 0; i < 3; i++) step(V_MD, $sformatf("st_md%0d", i));
    step(V_RUN, "st_md_adv");
    idle();
    EX_redirect = 1;
    step(V_FL, "st_fl");
    idle();
    check("stat_lu", stat_lu, 32'd2);
    check("stat_md", stat_md, 32'd3);
    check("stat_fl", stat_fl, 32'd1);
`endif

    if (sbq.size() != 0) check("sb_drain", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
